// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/FIFO-side bundle shared by the round-robin write arbiter.
// Ports (arbiter view, modport slave):
//   req           in  NUM_REQ             per-requester write request
//   din_flat      in  NUM_REQ*FIFO_WIDTH  requester i word at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   full          in  1                   FIFO full flag for the current cycle
//   gnt           out NUM_REQ             one-hot accept strobe
//   wen           out 1                   FIFO write enable
//   fifo_din      out FIFO_WIDTH          FIFO write data
//   busy          out 1                   burst tenure active
//   owner         out clog2(NUM_REQ)      current or last owner index
//   word_cnt_flat out NUM_REQ*16          per-requester accepted-word counters
// modport master is the producer/FIFO/testbench side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    localparam int OW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] din_flat;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wen;
    logic [FIFO_WIDTH-1:0]         fifo_din;
    logic                          busy;
    logic [OW-1:0]                 owner;
    logic [NUM_REQ*16-1:0]         word_cnt_flat;
    modport slave (
        input  req, din_flat, full,
        output gnt, wen, fifo_din, busy, owner, word_cnt_flat
    );
    modport master (
        output req, din_flat, full,
        input  gnt, wen, fifo_din, busy, owner, word_cnt_flat
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Ports:
//   i_clk    in  1  clock, all state changes on the rising edge
//   i_rst_n  in  1  asynchronous active-low reset
//   bus      fifo_wr_arbiter_if.slave  (req, din_flat, full in; gnt, wen, fifo_din, busy, owner, word_cnt_flat out)
// Optional feature: define FIFO_WR_ARB_STATS_EN to instantiate the saturating
// per-requester accepted-word counters; otherwise word_cnt_flat is tied to 0.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fifo_wr_arbiter_if.slave      bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]         r_state;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_cnt;
    logic [OW-1:0]      w_pick;
    logic [OW-1:0]      w_idx;
    logic [OW-1:0]      w_next_ptr;
    logic               w_busy;
    logic               w_own_req;
    logic               w_xfer;
    logic               w_last;
    logic [NUM_REQ-1:0] w_gnt;

    // Cyclic search from r_rr_ptr; scanning the offsets downward lets the smallest offset win.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = OW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (bus.req[w_idx]) w_pick = w_idx;
        end
    end

    assign w_busy     = (r_state == S_BURST);
    assign w_own_req  = bus.req[r_owner];
    assign w_xfer     = w_busy & w_own_req & ~bus.full;
    assign w_last     = (r_cnt == CW'(BURST_LEN - 1));
    assign w_next_ptr = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_gnt      = w_xfer ? (NUM_REQ'(1) << r_owner) : '0;

    assign bus.gnt      = w_gnt;
    assign bus.wen      = w_xfer;
    assign bus.busy     = w_busy;
    assign bus.owner    = r_owner;
    // Gated by busy so the write data is 0 while idle or held in reset.
    assign bus.fifo_din = w_busy ? bus.din_flat[r_owner*FIFO_WIDTH +: FIFO_WIDTH] : '0;

    // A full stall holds the tenure; a dropped owner request ends it regardless of full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            if (|bus.req) begin
                r_state <= S_BURST;
                r_owner <= w_pick;
                r_cnt   <= '0;
            end
        end else if (!w_own_req || (w_xfer && w_last)) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_wcnt [NUM_REQ];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (w_gnt[i] && r_wcnt[i] != 16'hFFFF) r_wcnt[i] <= r_wcnt[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign bus.word_cnt_flat[g*16 +: 16] = r_wcnt[g];
    end
`else
    assign bus.word_cnt_flat = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, BURST_LEN=4, FIFO_WIDTH=16).
// Ports: none; instantiates fifo_wr_arbiter_if and fifo_wr_arbiter.
// With FIFO_WR_ARB_STATS_EN defined, word_cnt_flat is checked against a grant-count model; otherwise against 0.
module tb_fifo_wr_arbiter;
    typedef struct packed {
        logic        rst_n;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [15:0] din;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        m_e;
    logic [15:0] dw [4] = '{16'h1111, 16'h00A5, 16'h2222, 16'h3333};
    logic [63:0] m_cnt;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .BURST_LEN(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // One cycle of stimulus with its hand-computed expected outputs.
    task automatic cyc(input logic rn, input logic [3:0] rq, input logic fl,
                       input logic eb, input logic [1:0] eo, input logic [3:0] eg);
        exp_t e;
        rst_n    = rn;
        bus.req  = rq;
        bus.full = fl;
        e.rst_n  = rn;
        e.gnt    = eg;
        e.busy   = eb;
        e.owner  = eo;
        e.din    = eb ? dw[eo] : 16'h0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial m_cnt = '0;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            if (!m_e.rst_n) m_cnt = '0;
            chk("gnt", 64'(bus.gnt), 64'(m_e.gnt));
            chk("wen", 64'(bus.wen), 64'(|m_e.gnt));
            chk("busy", 64'(bus.busy), 64'(m_e.busy));
            chk("owner", 64'(bus.owner), 64'(m_e.owner));
            chk("fifo_din", 64'(bus.fifo_din), 64'(m_e.din));
`ifdef FIFO_WR_ARB_STATS_EN
            chk("word_cnt", bus.word_cnt_flat, m_cnt);
            for (int i = 0; i < 4; i++)
                if (m_e.rst_n && m_e.gnt[i]) m_cnt[i*16 +: 16] = m_cnt[i*16 +: 16] + 16'd1;
`else
            chk("word_cnt", bus.word_cnt_flat, 64'h0);
`endif
        end
    end

    initial begin
        bus.req      = 4'h0;
        bus.full     = 1'b0;
        bus.din_flat = {dw[3], dw[2], dw[1], dw[0]};
        @(posedge clk);
        #1;
        // Reset with every request high: nothing granted.
        repeat (2) cyc(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0);
        // All requesting: owners 0,1,2,3,0 with one idle cycle between bursts.
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0);
        for (int b = 0; b < 5; b++) begin
            if (b > 0) cyc(1'b1, 4'hF, 1'b0, 1'b0, 2'(b - 1), 4'h0);
            repeat (4) cyc(1'b1, 4'hF, 1'b0, 1'b1, 2'(b), 4'b0001 << 2'(b));
        end
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        // Single requester 1, repeating bursts.
        for (int r = 0; r < 2; r++) begin
            cyc(1'b1, 4'b0010, 1'b0, 1'b0, 2'(r), 4'h0);
            repeat (4) cyc(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010);
        end
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd1, 4'h0);
        // Full stall after requester 0's second word; tenure kept, then owner 1.
        cyc(1'b1, 4'b0011, 1'b0, 1'b0, 2'd1, 4'h0);
        repeat (2) cyc(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001);
        repeat (3) cyc(1'b1, 4'b0011, 1'b1, 1'b1, 2'd0, 4'h0);
        repeat (2) cyc(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001);
        cyc(1'b1, 4'b0011, 1'b0, 1'b0, 2'd0, 4'h0);
        cyc(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010);
        cyc(1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 4'h0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd1, 4'h0);
        // Early release by requester 2 (while full): next owner is 3.
        cyc(1'b1, 4'b1100, 1'b0, 1'b0, 2'd1, 4'h0);
        cyc(1'b1, 4'b1100, 1'b0, 1'b1, 2'd2, 4'b0100);
        cyc(1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 4'h0);
        cyc(1'b1, 4'b1100, 1'b0, 1'b0, 2'd2, 4'h0);
        repeat (4) cyc(1'b1, 4'b1100, 1'b0, 1'b1, 2'd3, 4'b1000);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd3, 4'h0);
        // Reset mid-burst takes effect within the cycle and abandons the burst.
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 2'd3, 4'h0);
        cyc(1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001);
        cyc(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'h0);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'h0);
        cyc(1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001);
        cyc(1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's FIFO between `NUM_REQ` producers in one clock domain. Each producer raises a request with a data word. The arbiter grants one owner at a time for a bounded burst, drives the FIFO `wen`/`din` directly, and respects the FIFO `full` flag so that no word is ever lost or duplicated.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2–8.
- `FIFO_WIDTH`, default 16: data word width, matching the FIFO.
- `BURST_LEN`, default 4: maximum words accepted from one owner per tenure, at least 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester write request; data is valid while high.
- `din_flat` in `NUM_REQ*FIFO_WIDTH`: requester *i*'s word is at bits `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `gnt` out `NUM_REQ`: one-hot accept strobe; the word is consumed at the edge ending the cycle in which `gnt[i]` is high.
- `full` in 1: FIFO full flag.
- `wen` out 1: FIFO write enable.
- `fifo_din` out `FIFO_WIDTH`: FIFO write data.
- `busy` out 1: a burst tenure is active.
- `owner` out `clog2(NUM_REQ)`: current or last owner index.
- `word_cnt_flat` out `NUM_REQ*16`: per-requester accepted-word counters (see Configuration).

## Operation
- FSM has two states: `IDLE` and `BURST`. State registers are `state`, `owner`, `rr_ptr`, and `cnt` (0..`BURST_LEN`-1).
- In `IDLE`, if any `req` is high, the FSM selects the first requesting index at or after `rr_ptr` (cyclic search). At the next edge: `owner` ← that index, `cnt` ← 0, state ← `BURST`. No grant is issued in `IDLE`.
- In `BURST`, the grant and FIFO outputs are combinational:
  - `gnt[owner] = req[owner] & ~full`; all other `gnt` bits are 0.
  - `wen = |gnt`.
  - `fifo_din = din_flat[owner]`.
- Transfer with `cnt == BURST_LEN-1`: `rr_ptr` ← `owner+1` (wraps modulo `NUM_REQ`), state ← `IDLE`.
- Any other transfer: `cnt` ← `cnt+1`.
- `req[owner]` low in `BURST` (regardless of `full`): `rr_ptr` ← `owner+1` (mod `NUM_REQ`), state ← `IDLE`. This ends the tenure early.
- `full` high with `req[owner]` high: no transfer; `cnt`, `owner`, and state are held. The tenure is kept, not forfeited.
- Requests from non-owners are ignored until the FSM returns to `IDLE`. Requesters must hold `req` and data stable until `gnt` is seen.
- `busy` = (state == `BURST`).

## Timing
- Reset values: state `IDLE`, `owner` 0, `rr_ptr` 0, `cnt` 0, all counters 0.
- During reset, `gnt`, `wen`, and `busy` are 0 and `fifo_din` is 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-burst abandons the burst. Words already granted stay in the FIFO; no partial grant occurs.
- Arbitration latency: `req` rising in `IDLE` leads to the first `gnt` in the next cycle (1-cycle bubble).
- Every tenure end costs exactly one `IDLE` cycle.
- Peak throughput: `BURST_LEN` words per `BURST_LEN+1` cycles.
- `gnt` and `wen` have combinational paths from `req` and `full`. There is no path from `din_flat` to any control output.
- `full` is sampled in the same cycle as the write, so the FIFO must present `full` for the current cycle to prevent overflow.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - One 16-bit counter per requester, incremented on each cycle in which that requester's `gnt` bit is high.
  - Counters saturate at 16'hFFFF and are cleared only by `rst`.
  - Counter values are driven on `word_cnt_flat`.
- Not defined: counters are not instantiated and `word_cnt_flat` is tied to 0.

## Test plan
All cases use `NUM_REQ`=4, `BURST_LEN`=4, `FIFO_WIDTH`=16.
- Reset: `rst`=0, `req`=4'hF, `full`=0 -> `gnt`=0, `wen`=0, `busy`=0, `owner`=0. After release, the first grant goes to requester 0.
- Single requester: `req`=4'b0010, `din`[1]=16'h00A5 -> one idle cycle, then 4 cycles of `gnt`=4'b0010, `wen`=1, `fifo_din`=16'h00A5, then 1 idle cycle, repeating.
- All requesting: `req`=4'hF -> owner sequence 0,1,2,3,0, with 4 words each and one `wen`=0 cycle between bursts.
- Full stall: `full`=1 for 3 cycles after requester 0's 2nd word -> `wen`=0 for those 3 cycles, then exactly 2 more requester-0 words, then owner 1.
- Early release: requester 2 drops `req` after 1 word -> FSM returns to `IDLE`, and the next owner is 3, not 2.
- Stats (macro defined): after 20 cycles of `req`=4'hF, each `word_cnt` equals that requester's `gnt` pulse count. A forced preset of 16'hFFFE saturates at 16'hFFFF.
